west_port_arbiter: RTL and testbench
====================================

WEST_PORT_ARBITER -- requirements
Module: west_port_arbiter

Interface
REQ-001 SHALL have parameter CREDITS, default 4, meaning the downstream west input buffer depth in flits (range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port east_pkt, input, 16, the packet from the east input heading west; [15:12] is signed dx.
REQ-005 SHALL have port east_valid, input, 1, meaning east_pkt is valid.
REQ-006 SHALL have port east_ready, output, 1, meaning east_pkt is accepted this cycle when east_valid is also high.
REQ-007 SHALL have port local_pkt, input, 16, the packet from local injection heading west.
REQ-008 SHALL have port local_valid, input, 1, meaning local_pkt is valid.
REQ-009 SHALL have port local_ready, output, 1, meaning local_pkt is accepted this cycle when local_valid is also high.
REQ-010 SHALL have port west_pkt, output, 16, the registered packet driven onto the west link.
REQ-011 SHALL have port west_valid, output, 1, a one-cycle pulse per flit sent.
REQ-012 SHALL have port credit_in, input, 1, a one-cycle pulse from downstream meaning one buffer slot was freed.
REQ-013 SHALL have port credit_cnt, output, 3, the current available credits.
REQ-014 SHALL have port err_dx, output, 1, a one-cycle pulse meaning an accepted packet had dx >= 0 and was dropped.
REQ-015 SHALL have port err_credit, output, 1, a one-cycle pulse meaning credit_in arrived while credit_cnt == CREDITS.

Function
REQ-016 Arbitration SHALL be combinational: eligible = credit_cnt != 0, and credit_in in the same cycle does not make a requester eligible.
REQ-017 With one valid requester and eligible=1, that requester's ready SHALL be 1; the other ready SHALL be 0.
REQ-018 With both requesters valid and eligible=1, the requester not named by last_grant SHALL win (round-robin).
REQ-019 A ready SHALL never be high when eligible=0, and east_ready and local_ready SHALL never both be high.
REQ-020 last_grant SHALL update to the accepted requester on every accept, including dropped packets.
REQ-021 A legal accept (dx < 0) in cycle t SHALL produce west_valid=1 in cycle t+1.
REQ-022 On a legal accept, west_pkt SHALL be the accepted packet with [15:12] replaced by (dx+1) in 4-bit two's complement and [11:0] unchanged; for example, dx=-1 yields 0.
REQ-023 An illegal accept (dx >= 0) SHALL NOT assert west_valid, SHALL consume no credit, and SHALL pulse err_dx in cycle t+1.
REQ-024 west_pkt SHALL hold its last value when west_valid=0.
REQ-025 The credit counter SHALL update as next = credit_cnt - legal_send + credit_in, so a simultaneous send and credit leave it unchanged.
REQ-026 When credit_in=1, no legal send occurs, and credit_cnt==CREDITS, the counter SHALL saturate at CREDITS and err_credit SHALL pulse in the next cycle.
REQ-027 The counter SHALL never underflow; this is guaranteed by REQ-016.
REQ-028 Valid requesters SHALL be served strictly alternately when eligible every cycle, with no starvation beyond one grant.

Reset
REQ-029 While rst=1, the block SHALL set credit_cnt=CREDITS, last_grant=local (so east has first priority), west_pkt=16'h0000, west_valid=0, err_dx=0, and err_credit=0.
REQ-030 While rst=1, east_ready and local_ready SHALL both be 0; credit_in and requests in those cycles SHALL be ignored.
REQ-031 Reset mid-transfer SHALL discard any pending output pulse, with no west_valid in the cycle after rst deasserts unless a new accept occurs.

Verification
REQ-032 The bench SHALL check this scenario: after reset, east and local are both valid with dx=-3 each -> east is accepted first, west_pkt[15:12]=4'b1110 (-2) next cycle, then local is accepted, alternating each cycle.
REQ-033 The bench SHALL check this scenario: CREDITS=4, no credit_in, local is valid continuously -> exactly 4 west_valid pulses, then local_ready=0 and credit_cnt=0; one credit_in pulse -> exactly one further send.
REQ-034 The bench SHALL check this scenario: credit_cnt=0, credit_in=1 in the same cycle as local_valid=1 -> no accept that cycle, credit_cnt=1 next cycle, accept on the following cycle.
REQ-035 The bench SHALL check this scenario: east_pkt=16'h2ABC with east_valid=1 -> east_ready=1, err_dx pulse next cycle, no west_valid, credit_cnt unchanged, and last_grant=east.
REQ-036 The bench SHALL check this scenario: credit_cnt=CREDITS, credit_in=1, no send -> credit_cnt stays CREDITS and err_credit pulses once; a simultaneous send and credit_in -> credit_cnt unchanged.
REQ-037 The bench SHALL check this scenario: rst asserted in the cycle of an accept -> no west_valid afterwards, credit_cnt=CREDITS, and east has priority on the next contention.

Source files
------------

// File: rtl/west_port_arbiter.sv
// west_port_arbiter: round-robin east/local arbiter with dx check and credit flow control toward the west link
module west_port_arbiter #(
    parameter int CREDITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] east_pkt,
    input  logic        east_valid,
    output logic        east_ready,
    input  logic [15:0] local_pkt,
    input  logic        local_valid,
    output logic        local_ready,
    output logic [15:0] west_pkt,
    output logic        west_valid,
    input  logic        credit_in,
    output logic [2:0]  credit_cnt,
    output logic        err_dx,
    output logic        err_credit
);
    localparam logic [2:0] MAX = 3'(CREDITS);
    logic        last_east;
    logic        eligible;
    logic        accept;
    logic        legal;
    logic        full;
    logic [15:0] pkt;
    always_comb begin
        eligible    = !rst && credit_cnt != 3'd0;
        east_ready  = eligible && east_valid && (!local_valid || !last_east);
        local_ready = eligible && local_valid && !east_ready;
        accept      = east_ready || local_ready;
        pkt         = east_ready ? east_pkt : local_pkt;
        legal       = accept && pkt[15];
        full        = credit_cnt == MAX;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= MAX;
            last_east  <= 1'b0;
            west_pkt   <= 16'h0000;
            west_valid <= 1'b0;
            err_dx     <= 1'b0;
            err_credit <= 1'b0;
        end else begin
            west_valid <= legal;
            err_dx     <= accept && !legal;
            err_credit <= credit_in && !legal && full;
            if (legal) west_pkt <= {pkt[15:12] + 4'd1, pkt[11:0]};
            if (accept) last_east <= east_ready;
            if (!(credit_in && !legal && full)) credit_cnt <= credit_cnt + 3'(credit_in) - 3'(legal);
        end
    end
endmodule

// File: tb/tb_west_port_arbiter.sv
// tb_west_port_arbiter: directed scenario checks for west_port_arbiter
module tb_west_port_arbiter;
    localparam int CREDITS = 4;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] east_pkt, local_pkt, west_pkt;
    logic        east_valid, east_ready, local_valid, local_ready;
    logic        west_valid, credit_in, err_dx, err_credit;
    logic [2:0]  credit_cnt;
    int tests = 0;
    int fails = 0;
    west_port_arbiter #(.CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst),
        .east_pkt(east_pkt), .east_valid(east_valid), .east_ready(east_ready),
        .local_pkt(local_pkt), .local_valid(local_valid), .local_ready(local_ready),
        .west_pkt(west_pkt), .west_valid(west_valid),
        .credit_in(credit_in), .credit_cnt(credit_cnt),
        .err_dx(err_dx), .err_credit(err_credit)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        east_valid = 0; local_valid = 0; credit_in = 0;
    endtask
    task automatic test_reset();
        rst = 1; east_valid = 1; local_valid = 1; credit_in = 1;
        east_pkt = 16'hD123; local_pkt = 16'hD456;
        step(); step();
        tests++; if (credit_cnt !== 3'd4) begin fails++; $display("FAIL reset_credit got %0d want 4", credit_cnt); end
        tests++; if (west_valid !== 1'b0 || west_pkt !== 16'h0000) begin fails++; $display("FAIL reset_west got %b/%h want 0/0000", west_valid, west_pkt); end
        tests++; if (err_dx !== 1'b0 || err_credit !== 1'b0) begin fails++; $display("FAIL reset_err got %b%b want 00", err_dx, err_credit); end
        tests++; if (east_ready !== 1'b0 || local_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b%b want 00", east_ready, local_ready); end
        rst = 0; idle();
        step();
        tests++; if (credit_cnt !== 3'd4) begin fails++; $display("FAIL reset_ignore_credit got %0d want 4", credit_cnt); end
    endtask
    task automatic test_round_robin();
        east_pkt = 16'hD123; local_pkt = 16'hD456; east_valid = 1; local_valid = 1;
        #1;
        tests++; if (east_ready !== 1'b1 || local_ready !== 1'b0) begin fails++; $display("FAIL rr_first got e%b l%b want e1 l0", east_ready, local_ready); end
        step();
        tests++; if (west_valid !== 1'b1 || west_pkt !== 16'hE123) begin fails++; $display("FAIL rr_east_out got %b/%h want 1/e123", west_valid, west_pkt); end
        tests++; if (east_ready !== 1'b0 || local_ready !== 1'b1) begin fails++; $display("FAIL rr_second got e%b l%b want e0 l1", east_ready, local_ready); end
        step();
        tests++; if (west_valid !== 1'b1 || west_pkt !== 16'hE456 || credit_cnt !== 3'd2) begin fails++; $display("FAIL rr_local_out got %b/%h/%0d want 1/e456/2", west_valid, west_pkt, credit_cnt); end
        tests++; if (east_ready !== 1'b1 || local_ready !== 1'b0) begin fails++; $display("FAIL rr_third got e%b l%b want e1 l0", east_ready, local_ready); end
        idle(); credit_in = 1;
        step(); step();
        credit_in = 0;
        tests++; if (credit_cnt !== 3'd4) begin fails++; $display("FAIL rr_restore got %0d want 4", credit_cnt); end
    endtask
    task automatic test_credit_exhaust();
        int sends = 0;
        local_pkt = 16'hF00A; local_valid = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (west_valid) sends++;
        end
        tests++; if (sends != 4) begin fails++; $display("FAIL exhaust_sends got %0d want 4", sends); end
        tests++; if (local_ready !== 1'b0 || credit_cnt !== 3'd0 || west_pkt !== 16'h000A) begin fails++; $display("FAIL exhaust_state got r%b c%0d p%h want r0 c0 p000a", local_ready, credit_cnt, west_pkt); end
        credit_in = 1;
        #1;
        tests++; if (local_ready !== 1'b0) begin fails++; $display("FAIL credit_same_cycle got %b want 0", local_ready); end
        step();
        credit_in = 0;
        tests++; if (credit_cnt !== 3'd1 || west_valid !== 1'b0 || local_ready !== 1'b1) begin fails++; $display("FAIL credit_return got c%0d v%b r%b want c1 v0 r1", credit_cnt, west_valid, local_ready); end
        step();
        tests++; if (west_valid !== 1'b1 || credit_cnt !== 3'd0) begin fails++; $display("FAIL credit_send got v%b c%0d want v1 c0", west_valid, credit_cnt); end
        sends = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (west_valid) sends++;
        end
        tests++; if (sends != 0) begin fails++; $display("FAIL credit_extra got %0d want 0", sends); end
        idle(); credit_in = 1;
        for (int i = 0; i < 4; i++) step();
        credit_in = 0;
        tests++; if (credit_cnt !== 3'd4) begin fails++; $display("FAIL exhaust_restore got %0d want 4", credit_cnt); end
    endtask
    task automatic test_illegal_dx();
        east_pkt = 16'h2ABC; east_valid = 1;
        #1;
        tests++; if (east_ready !== 1'b1) begin fails++; $display("FAIL dx_ready got %b want 1", east_ready); end
        step();
        east_valid = 0;
        tests++; if (err_dx !== 1'b1 || west_valid !== 1'b0) begin fails++; $display("FAIL dx_pulse got e%b v%b want e1 v0", err_dx, west_valid); end
        tests++; if (credit_cnt !== 3'd4 || west_pkt !== 16'h000A) begin fails++; $display("FAIL dx_state got c%0d p%h want c4 p000a", credit_cnt, west_pkt); end
        step();
        tests++; if (err_dx !== 1'b0) begin fails++; $display("FAIL dx_once got %b want 0", err_dx); end
        east_pkt = 16'hD123; local_pkt = 16'hD456; east_valid = 1; local_valid = 1;
        #1;
        tests++; if (east_ready !== 1'b0 || local_ready !== 1'b1) begin fails++; $display("FAIL dx_last_grant got e%b l%b want e0 l1", east_ready, local_ready); end
        idle();
        step();
    endtask
    task automatic test_credit_overflow();
        credit_in = 1;
        step();
        credit_in = 0;
        tests++; if (err_credit !== 1'b1 || credit_cnt !== 3'd4) begin fails++; $display("FAIL ovf_pulse got e%b c%0d want e1 c4", err_credit, credit_cnt); end
        step();
        tests++; if (err_credit !== 1'b0) begin fails++; $display("FAIL ovf_once got %b want 0", err_credit); end
        local_pkt = 16'hE777; local_valid = 1; credit_in = 1;
        step();
        idle();
        tests++; if (credit_cnt !== 3'd4 || west_valid !== 1'b1 || err_credit !== 1'b0 || west_pkt !== 16'hF777) begin fails++; $display("FAIL send_and_credit got c%0d v%b e%b p%h want c4 v1 e0 pf777", credit_cnt, west_valid, err_credit, west_pkt); end
        step();
    endtask
    task automatic test_reset_mid();
        east_pkt = 16'hD123; local_pkt = 16'hD456; east_valid = 1;
        step();
        tests++; if (west_valid !== 1'b1 || credit_cnt !== 3'd3) begin fails++; $display("FAIL mid_pre got v%b c%0d want v1 c3", west_valid, credit_cnt); end
        rst = 1; local_valid = 1;
        #1;
        tests++; if (east_ready !== 1'b0 || local_ready !== 1'b0) begin fails++; $display("FAIL mid_ready got e%b l%b want 00", east_ready, local_ready); end
        step();
        rst = 0;
        #1;
        tests++; if (west_valid !== 1'b0 || credit_cnt !== 3'd4) begin fails++; $display("FAIL mid_state got v%b c%0d want v0 c4", west_valid, credit_cnt); end
        tests++; if (east_ready !== 1'b1 || local_ready !== 1'b0) begin fails++; $display("FAIL mid_priority got e%b l%b want e1 l0", east_ready, local_ready); end
        idle();
        step();
        tests++; if (west_valid !== 1'b0) begin fails++; $display("FAIL mid_no_pulse got %b want 0", west_valid); end
    endtask
    initial begin
        test_reset();
        test_round_robin();
        test_credit_exhaust();
        test_illegal_dx();
        test_credit_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
